mul2x2_dot_accumulator: RTL and testbench

//   Downstream consumer of the 2x2 multiplier. Accepts 2-bit operand pairs over a valid/ready

---
 rtl/mul2x2_pkg.sv | 6 +
 rtl/mul2x2_dot_accumulator_mult.sv | 10 +
 rtl/mul2x2_dot_accumulator.sv | 70 +++++++
 tb/tb_mul2x2_dot_accumulator.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mul2x2_pkg.sv
// mul2x2_pkg: operand/product widths and FSM state type shared by the dot-product accumulator.
package mul2x2_pkg;
    localparam int OPND_W = 2;
    localparam int PROD_W = 4;
    typedef enum logic {ST_ACCUM, ST_HOLD} dacc_state_t;
endpackage

// File: rtl/mul2x2_dot_accumulator_mult.sv
// Multiplier2x2: combinational 2-bit by 2-bit unsigned multiplier.
module Multiplier2x2
    import mul2x2_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] p
);
    assign p = PROD_W'(a) * PROD_W'(b);
endmodule

// File: rtl/mul2x2_dot_accumulator.sv
// mul2x2_dot_accumulator: sums 2x2 products of up to VEC_LEN terms and hands the result over valid/ready.
module mul2x2_dot_accumulator
    import mul2x2_pkg::*;
#(
    parameter int VEC_LEN = 4,
    parameter int ACC_W = 8,
    localparam int CNT_W = $clog2(VEC_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        a_in,
    input  logic [1:0]        b_in,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ACC_W-1:0]  sum_out,
    output logic [CNT_W-1:0]  sum_count,
    output logic              sum_ovf,
    output logic              sum_valid,
    input  logic              sum_ready
);
    dacc_state_t state;
    logic [PROD_W-1:0] p;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic ovf;
    logic [ACC_W:0] nxt;
    logic accept;
    logic close;

    Multiplier2x2 mult (.a(a_in), .b(b_in), .p(p));

    // top bit of nxt is this term's carry out of the accumulator
    assign nxt = {1'b0, acc} + (ACC_W+1)'(p);
    assign in_ready = !rst && state == ST_ACCUM;
    assign accept = in_valid && in_ready;
    assign close = in_last || cnt == CNT_W'(VEC_LEN - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ACCUM;
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            sum_out <= '0;
            sum_count <= '0;
            sum_ovf <= 1'b0;
            sum_valid <= 1'b0;
        end else if (state == ST_ACCUM) begin
            if (accept) begin
                acc <= nxt[ACC_W-1:0];
                cnt <= cnt + 1'b1;
                ovf <= ovf | nxt[ACC_W];
                if (close) begin
                    state <= ST_HOLD;
                    sum_out <= nxt[ACC_W-1:0];
                    sum_count <= cnt + 1'b1;
                    sum_ovf <= ovf | nxt[ACC_W];
                    sum_valid <= 1'b1;
                end
            end
        end else if (sum_ready) begin
            state <= ST_ACCUM;
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            sum_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mul2x2_dot_accumulator.sv
// tb_mul2x2_dot_accumulator: scoreboard bench driving a default instance and a narrow (VEC_LEN=2, ACC_W=4) instance.
module tb_mul2x2_dot_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] a_in = '0;
    logic [1:0] b_in = '0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic sum_ready = 1'b0;
    logic [1:0] rdy;
    logic [1:0] sv;
    logic [1:0] sov;
    logic [7:0] so [2];
    int total = 0;
    int bad = 0;
    int rmode = 1;

    always #5 clk = ~clk;

    // rmode: 0 = downstream stalls, 1 = always ready, 2 = random
    always @(posedge clk) begin
        #1;
        sum_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
    end

    task automatic chk(input string nm, input int id, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, id, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int VL = (g == 0) ? 4 : 2;
        localparam int AW = (g == 0) ? 8 : 4;
        localparam int CW = $clog2(VL + 1);
        logic [AW-1:0] s_out;
        logic [CW-1:0] s_cnt;
        logic s_ovf;
        int qs[$];
        int qc[$];
        int qo[$];
        int s = 0;
        int n = 0;
        bit lat = 0;
        bit held = 0;
        int h_out, h_cnt, h_ovf;

        mul2x2_dot_accumulator #(.VEC_LEN(VL), .ACC_W(AW)) dut (
            .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
            .in_valid(in_valid), .in_last(in_last), .in_ready(rdy[g]),
            .sum_out(s_out), .sum_count(s_cnt), .sum_ovf(s_ovf),
            .sum_valid(sv[g]), .sum_ready(sum_ready)
        );
        assign so[g] = 8'(s_out);
        assign sov[g] = s_ovf;

        // reference model: running integer sum, wrapped and overflow-judged only at close
        always @(negedge clk) begin
            if (rst) begin
                s = 0;
                n = 0;
                lat = 0;
                qs.delete();
                qc.delete();
                qo.delete();
            end else begin
                if (lat) chk("latency", g, int'(sv[g]), 1);
                lat = 0;
                if (in_valid && rdy[g]) begin
                    s += int'(a_in) * int'(b_in);
                    n++;
                    if (in_last || n == VL) begin
                        qs.push_back(s % (1 << AW));
                        qc.push_back(n);
                        qo.push_back(int'(s >= (1 << AW)));
                        s = 0;
                        n = 0;
                        lat = 1;
                    end
                end
            end
        end

        always @(negedge clk) begin
            chk("in_ready", g, int'(rdy[g]), int'(!rst && !sv[g]));
            if (rst) held = 0;
            else begin
                if (held) begin
                    chk("hold_sum", g, int'(s_out), h_out);
                    chk("hold_cnt", g, int'(s_cnt), h_cnt);
                    chk("hold_ovf", g, int'(s_ovf), h_ovf);
                end
                if (sv[g] && sum_ready) begin
                    if (qs.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious[%0d]: got sum_valid 1 expected no result", g);
                    end else begin
                        chk("sum_out", g, int'(s_out), qs.pop_front());
                        chk("sum_count", g, int'(s_cnt), qc.pop_front());
                        chk("sum_ovf", g, int'(s_ovf), qo.pop_front());
                    end
                end
                held = sv[g] && !sum_ready;
                h_out = int'(s_out);
                h_cnt = int'(s_cnt);
                h_ovf = int'(s_ovf);
            end
        end
    end

    // waits until both instances are ready so they see an identical term stream
    task automatic send(input int a, input int b, input bit last);
        int t = 0;
        while (rdy !== 2'b11 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got ready %b expected 11", rdy);
        end
        a_in = 2'(a);
        b_in = 2'(b);
        in_last = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic gap(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid", i, int'(sv[i]), 0);
            chk("rst_sum", i, int'(so[i]), 0);
            chk("rst_ovf", i, int'(sov[i]), 0);
            chk("rst_ready", i, int'(rdy[i]), 0);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) chk("ready_after_rst", i, int'(rdy[i]), 1);
        send(2, 1, 0); send(3, 2, 0); send(3, 3, 0); send(2, 2, 0);
        send(3, 3, 0); send(1, 1, 1); send(2, 3, 0); send(1, 2, 1);
        rmode = 0;
        send(2, 1, 1);
        a_in = 2'd3;
        b_in = 2'd3;
        in_valid = 1'b1;
        gap(5);
        for (int i = 0; i < 2; i++) chk("stall_ready", i, int'(rdy[i]), 0);
        in_valid = 1'b0;
        rmode = 1;
        sum_ready = 1'b1;
        send(3, 3, 0); send(3, 3, 0); send(1, 1, 0); send(1, 1, 1);
        send(3, 3, 0); send(3, 3, 0);
        rst = 1'b1;
        gap(1);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            gap($urandom_range(0, 2));
            send(1, 1, 0);
        end
        rmode = 2;
        repeat (300) begin
            gap($urandom_range(0, 2));
            send($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
        end
        rmode = 1;
        gap(10);
        chk("drain", 0, gi[0].qs.size(), 0);
        chk("drain", 1, gi[1].qs.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
